// File: rtl/miss_pkg.sv
// Shared types and sizing helpers for the L1 miss/fill engine.
package miss_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FILL
    } fsm_e;

    function automatic int line_width(input int bis);
        return 8 << bis;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ADDR_BITS_DEF      = 32;
    localparam int BLOCK_ID_START_DEF = 5;
    localparam int BUS_WIDTH_DEF      = 64;

    localparam int LINE_WIDTH = line_width(BLOCK_ID_START_DEF);
    localparam int BEATS      = LINE_WIDTH / BUS_WIDTH_DEF;
    localparam int CNT_W      = clog2_min1(BEATS);
    localparam int BLOCK_W    = ADDR_BITS_DEF - BLOCK_ID_START_DEF;

endpackage

// File: rtl/miss_addr_queue.sv
// Pending-miss FIFO of block IDs; entry 0 is always the head.
// Compares an incoming ID against every live entry for miss merging.
module miss_addr_queue
    import miss_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int ID_W  = 27
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [ID_W-1:0] i_id,
    output logic            o_dup,
    output logic            o_full,
    output logic            o_empty,
    output logic [ID_W-1:0] o_head
);

    localparam int IDX_W = clog2_min1(DEPTH);
    localparam logic [DEPTH-1:0] ONE = DEPTH'(1);

    logic [ID_W-1:0]  r_id [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] w_vld_pop;
    logic [IDX_W-1:0] w_wr_idx;

    // The entry leaving this cycle must not absorb a new miss.
    always_comb begin
        o_dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && r_id[i] == i_id && !(i == 0 && i_pop)) begin
                o_dup = 1'b1;
            end
        end
    end

    assign w_vld_pop = i_pop ? (r_vld >> 1) : r_vld;

    always_comb begin
        w_wr_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!w_vld_pop[i]) begin
                w_wr_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_id[i] <= '0;
            end
        end else begin
            if (i_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    r_id[i] <= r_id[i+1];
                end
            end
            if (i_push) begin
                r_id[w_wr_idx] <= i_id;
            end
            r_vld <= w_vld_pop | (i_push ? (ONE << w_wr_idx) : '0);
        end
    end

    assign o_full  = &r_vld;
    assign o_empty = !r_vld[0];
    assign o_head  = r_id[0];

endmodule

// File: rtl/miss_fill_handler.sv
// L1<->L2 miss engine: queues block misses, fetches one line at a time,
// assembles beats and writes the line back while notifying the ld/st buffers.
module miss_fill_handler
    import miss_pkg::*;
#(
    parameter int ADDR_BITS      = 32,
    parameter int BLOCK_ID_START = 5,
    parameter int BUS_WIDTH      = 64,
    parameter int PEND_DEPTH     = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  miss_valid,
    input  logic [ADDR_BITS-1:0]                  miss_address,
    output logic                                  miss_ready,
    output logic                                  l2_req_valid,
    output logic [ADDR_BITS-1:0]                  l2_req_address,
    input  logic                                  l2_req_ready,
    input  logic                                  l2_resp_valid,
    input  logic [BUS_WIDTH-1:0]                  l2_resp_data,
    input  logic                                  l2_resp_last,
    output logic                                  fill_valid,
    output logic [ADDR_BITS-1:0]                  fill_address,
    output logic [line_width(BLOCK_ID_START)-1:0] fill_data,
    output logic                                  valid_update,
    output logic [ADDR_BITS-1:0]                  update_address,
    output logic                                  busy,
    output logic                                  protocol_err
);

    localparam int LINE_W = line_width(BLOCK_ID_START);
    localparam int NBEATS = LINE_W / BUS_WIDTH;
    localparam int CW     = clog2_min1(NBEATS);
    localparam int BW     = ADDR_BITS - BLOCK_ID_START;
    localparam logic [CW-1:0] LAST_CNT = CW'(NBEATS - 1);

    fsm_e                     r_state;
    fsm_e                     w_next;
    logic [CW-1:0]            r_cnt;
    logic [LINE_W-1:0]        r_line;
    logic                     r_err;
    logic [BW-1:0]            w_miss_id;
    logic [BW-1:0]            w_head;
    logic [ADDR_BITS-1:0]     w_head_addr;
    logic [BLOCK_ID_START-1:0] w_unused_off;
    logic                     w_dup;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_beat;
    logic                     w_last_beat;

    assign w_miss_id    = miss_address[ADDR_BITS-1:BLOCK_ID_START];
    assign w_unused_off = miss_address[BLOCK_ID_START-1:0];
    assign w_pop        = (r_state == FILL);
    assign miss_ready   = !w_full | w_dup;
    assign w_push       = miss_valid & miss_ready & !w_dup;
    assign w_beat       = (r_state == WAIT) & l2_resp_valid;
    assign w_last_beat  = (r_cnt == LAST_CNT);
    assign w_head_addr  = {w_head, {BLOCK_ID_START{1'b0}}};

    miss_addr_queue #(
        .DEPTH (PEND_DEPTH),
        .ID_W  (BW)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_id    (w_miss_id),
        .o_dup   (w_dup),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_comb begin
        w_next       = r_state;
        l2_req_valid = 1'b0;
        fill_valid   = 1'b0;
        unique case (r_state)
            IDLE: if (!w_empty) w_next = REQ;
            REQ: begin
                l2_req_valid = 1'b1;
                if (l2_req_ready) w_next = WAIT;
            end
            WAIT: if (w_beat && w_last_beat) w_next = FILL;
            FILL: begin
                fill_valid = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Completion follows the beat count; l2_resp_last only flags errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_line  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_beat) begin
                for (int b = 0; b < NBEATS; b++) begin
                    if (r_cnt == CW'(b)) begin
                        r_line[b*BUS_WIDTH +: BUS_WIDTH] <= l2_resp_data;
                    end
                end
                r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
                if (l2_resp_last != w_last_beat) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign l2_req_address = l2_req_valid ? w_head_addr : '0;
    assign fill_address   = fill_valid ? w_head_addr : '0;
    assign fill_data      = fill_valid ? r_line : '0;
    assign valid_update   = fill_valid;
    assign update_address = fill_address;
    assign busy           = !w_empty | (r_state != IDLE);
    assign protocol_err   = r_err;

endmodule

// File: tb/tb_miss_fill_handler.sv
// Directed bench for miss_fill_handler: single fill, request stall, merging,
// full-queue backpressure, refetch in FILL, bad last flag and reset mid-fetch.
module tb_miss_fill_handler;
    import miss_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  miss_valid;
    logic [31:0]           miss_address;
    logic                  miss_ready;
    logic                  l2_req_valid;
    logic [31:0]           l2_req_address;
    logic                  l2_req_ready;
    logic                  l2_resp_valid;
    logic [63:0]           l2_resp_data;
    logic                  l2_resp_last;
    logic                  fill_valid;
    logic [31:0]           fill_address;
    logic [LINE_WIDTH-1:0] fill_data;
    logic                  valid_update;
    logic [31:0]           update_address;
    logic                  busy;
    logic                  protocol_err;

    int checks = 0;
    int errors = 0;
    int n_req  = 0;
    int n_fill = 0;

    always #5 clk = ~clk;

    miss_fill_handler #(
        .ADDR_BITS      (32),
        .BLOCK_ID_START (5),
        .BUS_WIDTH      (64),
        .PEND_DEPTH     (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .miss_valid     (miss_valid),
        .miss_address   (miss_address),
        .miss_ready     (miss_ready),
        .l2_req_valid   (l2_req_valid),
        .l2_req_address (l2_req_address),
        .l2_req_ready   (l2_req_ready),
        .l2_resp_valid  (l2_resp_valid),
        .l2_resp_data   (l2_resp_data),
        .l2_resp_last   (l2_resp_last),
        .fill_valid     (fill_valid),
        .fill_address   (fill_address),
        .fill_data      (fill_data),
        .valid_update   (valid_update),
        .update_address (update_address),
        .busy           (busy),
        .protocol_err   (protocol_err)
    );

    always @(posedge clk) begin
        if (l2_req_valid && l2_req_ready) n_req <= n_req + 1;
        if (fill_valid) n_fill <= n_fill + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] bt(input logic [31:0] seed, input int k);
        return {seed, 32'(k)};
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] seed);
        return {bt(seed, 3), bt(seed, 2), bt(seed, 1), bt(seed, 0)};
    endfunction

    task automatic miss(input logic [31:0] a, input logic exp_rdy);
        miss_valid   = 1'b1;
        miss_address = a;
        @(negedge clk);
        chk("miss_ready", miss_ready, exp_rdy);
        step();
        miss_valid = 1'b0;
    endtask

    task automatic do_req(input logic [31:0] a);
        int n;
        n = 0;
        @(negedge clk);
        while (!l2_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_valid", l2_req_valid, 1'b1);
        chk("req_addr", l2_req_address, a);
        l2_req_ready = 1'b1;
        step();
        l2_req_ready = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d, input logic last);
        l2_resp_valid = 1'b1;
        l2_resp_data  = d;
        l2_resp_last  = last;
        step();
        l2_resp_valid = 1'b0;
        l2_resp_last  = 1'b0;
    endtask

    task automatic send4(input logic [31:0] seed);
        for (int k = 0; k < 4; k++) beat(bt(seed, k), k == 3);
    endtask

    task automatic check_fill(input logic [31:0] a, input logic [255:0] d);
        @(negedge clk);
        chk("fill_valid", fill_valid, 1'b1);
        chk("valid_update", valid_update, 1'b1);
        chk("fill_address", fill_address, a);
        chk("update_address", update_address, a);
        chk("fill_data", fill_data, d);
    endtask

    int r0;
    int f0;

    initial begin
        rst           = 1'b1;
        miss_valid    = 1'b0;
        miss_address  = '0;
        l2_req_ready  = 1'b0;
        l2_resp_valid = 1'b0;
        l2_resp_data  = '0;
        l2_resp_last  = 1'b0;
        step();
        step();
        rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_miss_ready", miss_ready, 1'b1);
        chk("rst_req_valid", l2_req_valid, 1'b0);
        chk("rst_fill_valid", fill_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_perr", protocol_err, 1'b0);
        chk("rst_fill_data", fill_data, '0);

        // 1: single miss
        step();
        miss(32'h0000_1234, 1'b1);
        @(negedge clk);
        chk("t1_idle_no_req", l2_req_valid, 1'b0);
        chk("t1_busy", busy, 1'b1);
        do_req(32'h0000_1220);
        send4(32'hD0D0_0001);
        check_fill(32'h0000_1220, line_of(32'hD0D0_0001));
        step();
        @(negedge clk);
        chk("t1_fill_done", fill_valid, 1'b0);
        chk("t1_not_busy", busy, 1'b0);

        // 2: request stalled, stray beats ignored
        step();
        miss(32'h0000_2000, 1'b1);
        l2_resp_valid = 1'b1;
        l2_resp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        l2_resp_last  = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t2_req_hold", l2_req_valid, 1'b1);
            chk("t2_addr_hold", l2_req_address, 32'h0000_2000);
            step();
        end
        l2_resp_valid = 1'b0;
        l2_resp_last  = 1'b0;
        do_req(32'h0000_2000);
        send4(32'h2222_0002);
        check_fill(32'h0000_2000, line_of(32'h2222_0002));
        chk("t2_no_perr", protocol_err, 1'b0);
        step();

        // 3: merge of 0x104 into 0x100
        r0 = n_req;
        f0 = n_fill;
        miss(32'h0000_0100, 1'b1);
        do_req(32'h0000_0100);
        beat(bt(32'h3333_0003, 0), 1'b0);
        miss(32'h0000_0104, 1'b1);
        miss(32'h0000_0200, 1'b1);
        for (int k = 1; k < 4; k++) beat(bt(32'h3333_0003, k), k == 3);
        check_fill(32'h0000_0100, line_of(32'h3333_0003));
        step();
        do_req(32'h0000_0200);
        send4(32'h3333_0004);
        check_fill(32'h0000_0200, line_of(32'h3333_0004));
        step();
        step();
        @(negedge clk);
        chk("t3_req_count", n_req - r0, 2);
        chk("t3_fill_count", n_fill - f0, 2);
        chk("t3_not_busy", busy, 1'b0);

        // 4: full queue backpressure
        step();
        miss(32'h0000_0100, 1'b1);
        miss(32'h0000_0200, 1'b1);
        miss_valid   = 1'b1;
        miss_address = 32'h0000_0300;
        @(negedge clk);
        chk("t4_full_ready", miss_ready, 1'b0);
        do_req(32'h0000_0100);
        send4(32'h4444_0001);
        check_fill(32'h0000_0100, line_of(32'h4444_0001));
        chk("t4_ready_in_fill", miss_ready, 1'b0);
        step();
        @(negedge clk);
        chk("t4_ready_after_fill", miss_ready, 1'b1);
        step();
        miss_valid = 1'b0;
        do_req(32'h0000_0200);
        send4(32'h4444_0002);
        check_fill(32'h0000_0200, line_of(32'h4444_0002));
        step();
        do_req(32'h0000_0300);
        send4(32'h4444_0003);
        check_fill(32'h0000_0300, line_of(32'h4444_0003));
        step();

        // 5: miss to the block being filled is refetched
        miss(32'h0000_0100, 1'b1);
        do_req(32'h0000_0100);
        send4(32'h5555_0001);
        miss_valid   = 1'b1;
        miss_address = 32'h0000_0108;
        check_fill(32'h0000_0100, line_of(32'h5555_0001));
        chk("t5_ready_in_fill", miss_ready, 1'b1);
        step();
        miss_valid = 1'b0;
        do_req(32'h0000_0100);
        send4(32'h5555_0002);
        check_fill(32'h0000_0100, line_of(32'h5555_0002));
        step();
        @(negedge clk);
        chk("t5_not_busy", busy, 1'b0);

        // 6: early last flag, then reset in WAIT
        step();
        miss(32'h0000_0400, 1'b1);
        do_req(32'h0000_0400);
        beat(bt(32'h6666_0001, 0), 1'b0);
        beat(bt(32'h6666_0001, 1), 1'b1);
        @(negedge clk);
        chk("t6_perr_set", protocol_err, 1'b1);
        chk("t6_no_early_fill", fill_valid, 1'b0);
        beat(bt(32'h6666_0001, 2), 1'b0);
        beat(bt(32'h6666_0001, 3), 1'b0);
        check_fill(32'h0000_0400, line_of(32'h6666_0001));
        step();
        miss(32'h0000_0500, 1'b1);
        do_req(32'h0000_0500);
        beat(bt(32'h6666_0002, 0), 1'b0);
        beat(bt(32'h6666_0002, 1), 1'b0);
        @(negedge clk);
        chk("t6_perr_sticky", protocol_err, 1'b1);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("t6_rst_fill", fill_valid, 1'b0);
        chk("t6_rst_req", l2_req_valid, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_perr", protocol_err, 1'b0);
        chk("t6_rst_ready", miss_ready, 1'b1);
        step();
        rst = 1'b0;
        beat(bt(32'hDEAD_0000, 2), 1'b0);
        beat(bt(32'hDEAD_0000, 3), 1'b1);
        @(negedge clk);
        chk("t6_stray_busy", busy, 1'b0);
        chk("t6_stray_fill", fill_valid, 1'b0);
        chk("t6_stray_perr", protocol_err, 1'b0);
        step();
        miss(32'h0000_0600, 1'b1);
        do_req(32'h0000_0600);
        send4(32'h6666_0003);
        check_fill(32'h0000_0600, line_of(32'h6666_0003));
        chk("t6_clean_perr", protocol_err, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
